// File: rtl/reservation_station.sv
// ALU/branch issue queue: holds dispatched ops, resolves operand tags from CDB/LDB, issues one ready op per cycle.
// Optional macro RS_AGE_SELECT_EN: issue the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int RS_BIT  = 3,
  parameter int ROB_BIT = 4,
  parameter int DAT_W   = 32,
  parameter int OP_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               br_flag,
  input  logic               rf_en_i,
  input  logic               rf_ic_i,
  input  logic [OP_W-1:0]    rf_op_i,
  input  logic [DAT_W-1:0]   rf_imm_i,
  input  logic [ROB_BIT-1:0] rf_qj_i,
  input  logic [ROB_BIT-1:0] rf_qk_i,
  input  logic [DAT_W-1:0]   rf_vj_i,
  input  logic [DAT_W-1:0]   rf_vk_i,
  input  logic [ROB_BIT-1:0] rf_qd_i,
  input  logic [DAT_W-1:0]   rf_pc_i,
  input  logic               cdb_en_i,
  input  logic [ROB_BIT-1:0] cdb_q_i,
  input  logic [DAT_W-1:0]   cdb_v_i,
  input  logic               ldb_en_i,
  input  logic [ROB_BIT-1:0] ldb_q_i,
  input  logic [DAT_W-1:0]   ldb_v_i,
  output logic               full_o,
  output logic               alu_en_o,
  output logic               alu_ic_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic [DAT_W-1:0]   alu_imm_o,
  output logic [DAT_W-1:0]   alu_vj_o,
  output logic [DAT_W-1:0]   alu_vk_o,
  output logic [ROB_BIT-1:0] alu_qd_o,
  output logic [DAT_W-1:0]   alu_pc_o
);

  typedef struct packed {
    logic               busy;
    logic               ic;
    logic [OP_W-1:0]    op;
    logic [DAT_W-1:0]   imm;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] qk;
    logic [DAT_W-1:0]   vj;
    logic [DAT_W-1:0]   vk;
    logic [ROB_BIT-1:0] qd;
    logic [DAT_W-1:0]   pc;
  } ent_t;

  ent_t               ent_q [RS_SIZE];
  ent_t               ent_d [RS_SIZE];
  ent_t               new_ent;
  logic [RS_SIZE-1:0] rdy;
  logic [RS_SIZE-1:0] free;
  logic               iss_vld;
  logic               free_vld;
  logic [RS_BIT-1:0]  iss_idx;
  logic [RS_BIT-1:0]  free_idx;
  logic [RS_BIT:0]    free_cnt;

  logic               alu_en_q;
  logic               alu_ic_q;
  logic [OP_W-1:0]    alu_op_q;
  logic [DAT_W-1:0]   alu_imm_q;
  logic [DAT_W-1:0]   alu_vj_q;
  logic [DAT_W-1:0]   alu_vk_q;
  logic [ROB_BIT-1:0] alu_qd_q;
  logic [DAT_W-1:0]   alu_pc_q;

  // Tag 0 means "value already present", so it never matches a broadcast.
  function automatic logic tag_hit(input logic bc_en, input logic [ROB_BIT-1:0] bc_q,
                                   input logic [ROB_BIT-1:0] q);
    return bc_en && (q != '0) && (bc_q == q);
  endfunction

  always_comb begin
    rdy      = '0;
    free     = '0;
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      rdy[i]   = ent_q[i].busy && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
      free[i]  = !ent_q[i].busy;
      free_cnt = free_cnt + (RS_BIT+1)'(free[i]);
    end
  end

  assign full_o = (free_cnt < (RS_BIT+1)'(2));

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_vld = 1'b1;
        free_idx = RS_BIT'(i);
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  logic [RS_BIT-1:0] age_q [RS_SIZE];
  logic [RS_BIT-1:0] age_d [RS_SIZE];
  logic [RS_BIT-1:0] best_age;

  // Strict greater-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    iss_vld  = 1'b0;
    iss_idx  = '0;
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rdy[i] && (!iss_vld || (age_q[i] > best_age))) begin
        iss_vld  = 1'b1;
        iss_idx  = RS_BIT'(i);
        best_age = age_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      age_d[i] = age_q[i];
      if (rf_en_i && free_vld && ent_q[i].busy && (age_q[i] != '1))
        age_d[i] = age_q[i] + 1'b1;
    end
    if (rf_en_i && free_vld)
      age_d[free_idx] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
    end else if (!br_flag && en) begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    iss_vld = 1'b0;
    iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        iss_vld = 1'b1;
        iss_idx = RS_BIT'(i);
      end
    end
  end
`endif

  // Operands broadcast in the dispatch cycle are captured directly into the new entry.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.ic   = rf_ic_i;
    new_ent.op   = rf_op_i;
    new_ent.imm  = rf_imm_i;
    new_ent.qj   = rf_qj_i;
    new_ent.qk   = rf_qk_i;
    new_ent.vj   = rf_vj_i;
    new_ent.vk   = rf_vk_i;
    new_ent.qd   = rf_qd_i;
    new_ent.pc   = rf_pc_i;
    if (tag_hit(cdb_en_i, cdb_q_i, rf_qj_i)) begin
      new_ent.qj = '0;
      new_ent.vj = cdb_v_i;
    end else if (tag_hit(ldb_en_i, ldb_q_i, rf_qj_i)) begin
      new_ent.qj = '0;
      new_ent.vj = ldb_v_i;
    end
    if (tag_hit(cdb_en_i, cdb_q_i, rf_qk_i)) begin
      new_ent.qk = '0;
      new_ent.vk = cdb_v_i;
    end else if (tag_hit(ldb_en_i, ldb_q_i, rf_qk_i)) begin
      new_ent.qk = '0;
      new_ent.vk = ldb_v_i;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        if (tag_hit(cdb_en_i, cdb_q_i, ent_q[i].qj)) begin
          ent_d[i].qj = '0;
          ent_d[i].vj = cdb_v_i;
        end else if (tag_hit(ldb_en_i, ldb_q_i, ent_q[i].qj)) begin
          ent_d[i].qj = '0;
          ent_d[i].vj = ldb_v_i;
        end
        if (tag_hit(cdb_en_i, cdb_q_i, ent_q[i].qk)) begin
          ent_d[i].qk = '0;
          ent_d[i].vk = cdb_v_i;
        end else if (tag_hit(ldb_en_i, ldb_q_i, ent_q[i].qk)) begin
          ent_d[i].qk = '0;
          ent_d[i].vk = ldb_v_i;
        end
      end
    end
    // Dispatch picks from the pre-edge free map, so it never lands on the slot issuing now.
    if (iss_vld)
      ent_d[iss_idx].busy = 1'b0;
    if (rf_en_i && free_vld)
      ent_d[free_idx] = new_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_en_q  <= 1'b0;
      alu_ic_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_imm_q <= '0;
      alu_vj_q  <= '0;
      alu_vk_q  <= '0;
      alu_qd_q  <= '0;
      alu_pc_q  <= '0;
    end else if (br_flag) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      alu_en_q <= 1'b0;
    end else if (!en) begin
      alu_en_q <= 1'b0;
    end else begin
      ent_q    <= ent_d;
      alu_en_q <= iss_vld;
      if (iss_vld) begin
        alu_ic_q  <= ent_q[iss_idx].ic;
        alu_op_q  <= ent_q[iss_idx].op;
        alu_imm_q <= ent_q[iss_idx].imm;
        alu_vj_q  <= ent_q[iss_idx].vj;
        alu_vk_q  <= ent_q[iss_idx].vk;
        alu_qd_q  <= ent_q[iss_idx].qd;
        alu_pc_q  <= ent_q[iss_idx].pc;
      end
    end
  end

  assign alu_en_o  = alu_en_q;
  assign alu_ic_o  = alu_ic_q;
  assign alu_op_o  = alu_op_q;
  assign alu_imm_o = alu_imm_q;
  assign alu_vj_o  = alu_vj_q;
  assign alu_vk_o  = alu_vk_q;
  assign alu_qd_o  = alu_qd_q;
  assign alu_pc_o  = alu_pc_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: stimulus pushes expected issues (with issue edge), a monitor pops on alu_en_o.
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst, en, br_flag;
  logic        rf_en_i, rf_ic_i;
  logic [5:0]  rf_op_i;
  logic [31:0] rf_imm_i, rf_vj_i, rf_vk_i, rf_pc_i;
  logic [3:0]  rf_qj_i, rf_qk_i, rf_qd_i;
  logic        cdb_en_i, ldb_en_i;
  logic [3:0]  cdb_q_i, ldb_q_i;
  logic [31:0] cdb_v_i, ldb_v_i;
  logic        full_o, alu_en_o, alu_ic_o;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_imm_o, alu_vj_o, alu_vk_o, alu_pc_o;
  logic [3:0]  alu_qd_o;

  reservation_station dut (
    .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
    .rf_en_i(rf_en_i), .rf_ic_i(rf_ic_i), .rf_op_i(rf_op_i), .rf_imm_i(rf_imm_i),
    .rf_qj_i(rf_qj_i), .rf_qk_i(rf_qk_i), .rf_vj_i(rf_vj_i), .rf_vk_i(rf_vk_i),
    .rf_qd_i(rf_qd_i), .rf_pc_i(rf_pc_i),
    .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
    .ldb_en_i(ldb_en_i), .ldb_q_i(ldb_q_i), .ldb_v_i(ldb_v_i),
    .full_o(full_o), .alu_en_o(alu_en_o), .alu_ic_o(alu_ic_o), .alu_op_o(alu_op_o),
    .alu_imm_o(alu_imm_o), .alu_vj_o(alu_vj_o), .alu_vk_o(alu_vk_o),
    .alu_qd_o(alu_qd_o), .alu_pc_o(alu_pc_o)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          edge_no;
    logic        ic;
    logic [5:0]  op;
    logic [31:0] imm, vj, vk, pc;
    logic [3:0]  qd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ed, input logic ic, input logic [5:0] op, input logic [31:0] imm,
                      input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] qd,
                      input logic [31:0] pc);
    exp_t e;
    e.edge_no = ed; e.ic = ic; e.op = op; e.imm = imm;
    e.vj = vj; e.vk = vk; e.qd = qd; e.pc = pc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && alu_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual qd=%0h pc=%0h required no issue", alu_qd_o, alu_pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_edge", edge_n, e.edge_no);
        chk("issue_data", {alu_ic_o, alu_op_o, alu_imm_o, alu_vj_o, alu_vk_o, alu_qd_o, alu_pc_o},
                          {e.ic, e.op, e.imm, e.vj, e.vk, e.qd, e.pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rf_en_i = 1'b0; cdb_en_i = 1'b0; ldb_en_i = 1'b0; br_flag = 1'b0;
  endtask

  task automatic disp(input logic ic, input logic [5:0] op, input logic [31:0] imm,
                      input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [3:0] qd, input logic [31:0] pc);
    rf_en_i = 1'b1; rf_ic_i = ic; rf_op_i = op; rf_imm_i = imm;
    rf_qj_i = qj; rf_qk_i = qk; rf_vj_i = vj; rf_vk_i = vk; rf_qd_i = qd; rf_pc_i = pc;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; idle();
    rf_ic_i = 0; rf_op_i = 0; rf_imm_i = 0; rf_qj_i = 0; rf_qk_i = 0;
    rf_vj_i = 0; rf_vk_i = 0; rf_qd_i = 0; rf_pc_i = 0;
    cdb_q_i = 0; cdb_v_i = 0; ldb_q_i = 0; ldb_v_i = 0;
    step(); step();
    chk("reset_alu_en", alu_en_o, 1'b0);
    chk("reset_full", full_o, 1'b0);
    chk("reset_alu_vj", alu_vj_o, 32'h0);
    rst = 1'b0;
    step();

    // Ready-at-dispatch: issues one edge after the dispatch edge.
    disp(1'b0, 6'h01, 32'h0, 4'd0, 4'd0, 32'd3, 32'd4, 4'd5, 32'h100);
    push(edge_n + 2, 1'b0, 6'h01, 32'h0, 32'd3, 32'd4, 4'd5, 32'h100);
    step(); idle(); repeat (3) step();
    chk("hold_alu_qd", alu_qd_o, 4'd5);
    chk("hold_alu_en", alu_en_o, 1'b0);

    // CDB wakeup two cycles after dispatch.
    disp(1'b0, 6'h02, 32'h0, 4'd7, 4'd0, 32'hDEAD, 32'd9, 4'd3, 32'h104);
    step(); idle(); step();
    cdb_en_i = 1'b1; cdb_q_i = 4'd7; cdb_v_i = 32'h55;
    push(edge_n + 2, 1'b0, 6'h02, 32'h0, 32'h55, 32'd9, 4'd3, 32'h104);
    step(); idle(); repeat (3) step();

    // LDB broadcast in the dispatch cycle resolves qk on entry.
    disp(1'b1, 6'h03, 32'h10, 4'd0, 4'd2, 32'd1, 32'h11, 4'd6, 32'h108);
    ldb_en_i = 1'b1; ldb_q_i = 4'd2; ldb_v_i = 32'hAA;
    push(edge_n + 2, 1'b1, 6'h03, 32'h10, 32'd1, 32'hAA, 4'd6, 32'h108);
    step(); idle(); repeat (3) step();

    // Freeze for three edges: ready entry waits, dispatch during freeze is ignored.
    disp(1'b0, 6'h04, 32'h0, 4'd0, 4'd0, 32'h21, 32'h22, 4'd7, 32'h10C);
    push(edge_n + 5, 1'b0, 6'h04, 32'h0, 32'h21, 32'h22, 4'd7, 32'h10C);
    step(); idle();
    en = 1'b0;
    disp(1'b0, 6'h05, 32'h0, 4'd0, 4'd0, 32'd1, 32'd1, 4'd8, 32'h110);
    step(); idle(); step(); step();
    en = 1'b1;
    step(); repeat (3) step();

    // Fill with unresolved entries; full_o tracks free count < 2.
    for (int i = 0; i < 7; i++) begin
      disp(1'b0, 6'h06, 32'h0, 4'(8 + i), 4'd0, 32'h0, 32'h0, 4'(i), 32'h200 + i);
      step();
      if (i == 4) chk("full_at_5_busy", full_o, 1'b0);
    end
    chk("full_at_7_busy", full_o, 1'b1);
    disp(1'b0, 6'h06, 32'h0, 4'd15, 4'd0, 32'h0, 32'h0, 4'd9, 32'h220);
    step();
    chk("full_at_8_busy", full_o, 1'b1);
    disp(1'b0, 6'h07, 32'h0, 4'd0, 4'd0, 32'h1, 32'h1, 4'd10, 32'h224);
    step();
    br_flag = 1'b1;
    disp(1'b0, 6'h07, 32'h0, 4'd0, 4'd0, 32'h2, 32'h2, 4'd11, 32'h228);
    step(); idle();
    chk("full_after_flush", full_o, 1'b0);
    cdb_en_i = 1'b1; cdb_q_i = 4'd8; cdb_v_i = 32'h1;
    step(); idle(); repeat (3) step();

    // idx1 older, idx0 newer, both woken on the same edge.
    disp(1'b0, 6'h08, 32'h0, 4'd0, 4'd0, 32'h31, 32'h0, 4'd1, 32'h300);
    push(edge_n + 2, 1'b0, 6'h08, 32'h0, 32'h31, 32'h0, 4'd1, 32'h300);
    step();
    disp(1'b0, 6'h09, 32'h0, 4'd4, 4'd0, 32'hFFFF, 32'h42, 4'd2, 32'h304);
    step();
    disp(1'b0, 6'h0A, 32'h0, 4'd0, 4'd5, 32'h51, 32'hFFFF, 4'd3, 32'h308);
    step(); idle();
    cdb_en_i = 1'b1; cdb_q_i = 4'd4; cdb_v_i = 32'hB4;
    ldb_en_i = 1'b1; ldb_q_i = 4'd5; ldb_v_i = 32'hC5;
`ifdef RS_AGE_SELECT_EN
    push(edge_n + 2, 1'b0, 6'h09, 32'h0, 32'hB4, 32'h42, 4'd2, 32'h304);
    push(edge_n + 3, 1'b0, 6'h0A, 32'h0, 32'h51, 32'hC5, 4'd3, 32'h308);
`else
    push(edge_n + 2, 1'b0, 6'h0A, 32'h0, 32'h51, 32'hC5, 4'd3, 32'h308);
    push(edge_n + 3, 1'b0, 6'h09, 32'h0, 32'hB4, 32'h42, 4'd2, 32'h304);
`endif
    step(); idle(); repeat (4) step();

    // Mid-run async reset with 5 pending entries; none may issue afterwards.
    for (int i = 0; i < 5; i++) begin
      disp(1'b0, 6'h0B, 32'h0, 4'(1 + i), 4'd0, 32'h0, 32'h0, 4'(i), 32'h400 + i);
      step();
    end
    idle();
    #1 rst = 1'b1;
    #1;
    chk("midrst_alu_en", alu_en_o, 1'b0);
    chk("midrst_full", full_o, 1'b0);
    chk("midrst_alu_qd", alu_qd_o, 4'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cdb_en_i = 1'b1; cdb_q_i = 4'(1 + i); cdb_v_i = 32'h77;
      step();
    end
    idle(); repeat (4) step();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
